tt_light_monitor: RTL and testbench

On-chip checker for the receiving end of the traffic-light output interface. Samples the two-direction red/yellow/green light vector driven by the traffic-light controller, tracks the current phase and per-light dwell time, and flags illegal encodings, conflicting greens, illegal colour sequences and too-short dwells. Sits beside the controller inside the user project; outputs a sticky error, the first-priority error code and a saturating violation count.

---
 rtl/tt_light_mon_pkg.sv | 73 +++++++
 rtl/tt_light_dwell.sv | 96 +++++++++
 rtl/tt_light_monitor.sv | 195 +++++++++++++++++++
 tb/tb_tt_light_monitor.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_light_mon_pkg.sv
// -----------------------------------------------------------------------------
// tt_light_mon_pkg
// Shared definitions for the traffic-light output monitor: light bit
// positions, one-hot light constants, violation codes, decoded phases and
// small helper functions used by tt_light_dwell and tt_light_monitor.
// Optional feature macro used by the importing files: TT_LIGHT_MON_DWELL_EN.
// -----------------------------------------------------------------------------
package tt_light_mon_pkg;

    // Light vector layout {R,Y,G}
    localparam int LIGHT_W = 3;
    localparam int R_BIT   = 2;
    localparam int Y_BIT   = 1;
    localparam int G_BIT   = 0;

    localparam logic [LIGHT_W-1:0] LIGHT_RED    = 3'b100;
    localparam logic [LIGHT_W-1:0] LIGHT_YELLOW = 3'b010;
    localparam logic [LIGHT_W-1:0] LIGHT_GREEN  = 3'b001;

    // Violation counter
    localparam int                  VIOL_CNT_W   = 8;
    localparam logic [VIOL_CNT_W-1:0] VIOL_CNT_MAX = '1;

    // Violation codes, lowest value has highest priority
    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_ENCODING = 3'd1,
        ERR_CONFLICT = 3'd2,
        ERR_SEQUENCE = 3'd3,
        ERR_DWELL    = 3'd4
    } err_code_e;

    // Decoded intersection phase
    typedef enum logic [1:0] {
        PHASE_ALL_RED = 2'd0,
        PHASE_NS_GO   = 2'd1,
        PHASE_EW_GO   = 2'd2,
        PHASE_INVALID = 2'd3
    } phase_e;

    // True when exactly one lamp of a direction is lit
    function automatic logic is_one_hot(input logic [LIGHT_W-1:0] l);
        return (l == LIGHT_RED) || (l == LIGHT_YELLOW) || (l == LIGHT_GREEN);
    endfunction

    // True for the three allowed colour changes G->Y, Y->R, R->G
    function automatic logic is_legal_step(input logic [LIGHT_W-1:0] prev_l,
                                           input logic [LIGHT_W-1:0] cur_l);
        return ((prev_l == LIGHT_GREEN)  && (cur_l == LIGHT_YELLOW)) ||
               ((prev_l == LIGHT_YELLOW) && (cur_l == LIGHT_RED))    ||
               ((prev_l == LIGHT_RED)    && (cur_l == LIGHT_GREEN));
    endfunction

    // A direction "goes" when it shows green or yellow
    function automatic logic is_go(input logic [LIGHT_W-1:0] l);
        return (l == LIGHT_GREEN) || (l == LIGHT_YELLOW);
    endfunction

    function automatic phase_e decode_phase(input logic [LIGHT_W-1:0] ns_l,
                                            input logic [LIGHT_W-1:0] ew_l);
        phase_e ph;
        ph = PHASE_INVALID;
        if ((ns_l == LIGHT_RED) && (ew_l == LIGHT_RED)) begin
            ph = PHASE_ALL_RED;
        end else if (is_go(ns_l) && (ew_l == LIGHT_RED)) begin
            ph = PHASE_NS_GO;
        end else if (is_go(ew_l) && (ns_l == LIGHT_RED)) begin
            ph = PHASE_EW_GO;
        end
        return ph;
    endfunction

endpackage

// File: rtl/tt_light_dwell.sv
// -----------------------------------------------------------------------------
// tt_light_dwell
// Per-direction tracker: holds the current and previous sampled colour,
// counts how long the current colour has been shown and reports sequence
// and dwell violations for that direction.
// Dwell counter and dwell check exist only when TT_LIGHT_MON_DWELL_EN is
// defined; otherwise dwell_viol_o is tied low.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   en_i          enabled cycle: sample light_i, advance dwell counter
//   tick_i        dwell tick (qualified by en_i)
//   valid_i       prev holds a real sample; gates both violation outputs
//   light_i       raw {R,Y,G} lights for this direction
//   cur_o         registered current colour
//   seq_viol_o    colour change outside G->Y, Y->R, R->G
//   dwell_viol_o  left G or Y before the minimum dwell
// -----------------------------------------------------------------------------
module tt_light_dwell
    import tt_light_mon_pkg::*;
#(
    parameter int MIN_GREEN  = 4,
    parameter int MIN_YELLOW = 2,
    parameter int DWELL_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic               tick_i,
    input  logic               valid_i,
    input  logic [LIGHT_W-1:0] light_i,
    output logic [LIGHT_W-1:0] cur_o,
    output logic               seq_viol_o,
    output logic               dwell_viol_o
);

    logic [LIGHT_W-1:0] cur_q;
    logic [LIGHT_W-1:0] prev_q;
    logic               changed;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours (prev_q gets the old cur_q).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q  <= LIGHT_RED;
            prev_q <= LIGHT_RED;
        end else if (en_i) begin
            prev_q <= cur_q;
            cur_q  <= light_i;
        end
    end

    assign changed    = (cur_q != prev_q);
    assign cur_o      = cur_q;
    assign seq_viol_o = valid_i && changed && !is_legal_step(prev_q, cur_q);

`ifdef TT_LIGHT_MON_DWELL_EN
    localparam logic [DWELL_W-1:0] DWELL_MAX = '1;
    localparam logic [DWELL_W-1:0] MIN_G     = DWELL_W'(MIN_GREEN);
    localparam logic [DWELL_W-1:0] MIN_Y     = DWELL_W'(MIN_YELLOW);

    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_d;

    // The counter clears one edge after the change becomes visible in
    // cur/prev, so during the change cycle dwell_q still holds the time
    // spent in the colour being left, which is what the check needs.
    // NOTE: dwell_d gets a default before any branch so no latch is inferred.
    always_comb begin
        dwell_d = dwell_q;
        if (changed) begin
            dwell_d = '0;
        end else if (tick_i && (dwell_q != DWELL_MAX)) begin
            dwell_d = dwell_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q <= '0;
        end else if (en_i) begin
            dwell_q <= dwell_d;
        end
    end

    assign dwell_viol_o = valid_i && changed &&
                          (((prev_q == LIGHT_GREEN)  && (dwell_q < MIN_G)) ||
                           ((prev_q == LIGHT_YELLOW) && (dwell_q < MIN_Y)));
`else
    // Dwell checking not built: the tick and dwell limits have no effect.
    logic unused_dwell_cfg;
    assign unused_dwell_cfg = ^{tick_i, 32'(MIN_GREEN), 32'(MIN_YELLOW), 32'(DWELL_W)};
    assign dwell_viol_o     = 1'b0;
`endif

endmodule

// File: rtl/tt_light_monitor.sv
// -----------------------------------------------------------------------------
// tt_light_monitor
// Checker for the traffic-light controller output. Registers both
// directions' {R,Y,G} lights, decodes the phase and flags, in priority
// order: 1 bad encoding, 2 conflicting go, 3 illegal colour sequence,
// 4 too-short dwell. Keeps a sticky error, the most recent code and a
// saturating violation count.
// Optional feature: TT_LIGHT_MON_DWELL_EN builds the tick prescaler, dwell
// counters and code-4 check; without it CLK_DIV/MIN_*/DWELL_W are unused.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   ena          enable; low freezes every register (clr ignored too)
//   ns_light     north-south lights {R,Y,G}
//   ew_light     east-west lights {R,Y,G}
//   clr          synchronous clear of err/err_code/viol_cnt
//   err          sticky error flag
//   err_code     code of most recent violation (0 none)
//   viol_cnt     violation count, saturating at 255
//   phase        0 ALL_RED, 1 NS_GO, 2 EW_GO, 3 INVALID
// -----------------------------------------------------------------------------
module tt_light_monitor
    import tt_light_mon_pkg::*;
#(
    parameter int CLK_DIV    = 1,
    parameter int MIN_GREEN  = 4,
    parameter int MIN_YELLOW = 2,
    parameter int DWELL_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [LIGHT_W-1:0]    ns_light,
    input  logic [LIGHT_W-1:0]    ew_light,
    input  logic                  clr,
    output logic                  err,
    output logic [2:0]            err_code,
    output logic [VIOL_CNT_W-1:0] viol_cnt,
    output logic [1:0]            phase
);

    // -------------------------------------------------------------------------
    // Dwell tick
    // -------------------------------------------------------------------------
    logic tick;

`ifdef TT_LIGHT_MON_DWELL_EN
    localparam int                 PRESC_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;

    // Tick on the enabled cycle where the prescaler wraps; CLK_DIV=1 ticks
    // every enabled cycle.
    assign tick    = (presc_q == PRESC_LAST);
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (ena) begin
            presc_q <= presc_d;
        end
    end
`else
    logic unused_clk_div;
    assign unused_clk_div = ^32'(CLK_DIV);
    assign tick           = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Sample-valid pipeline: sampled_q marks cur as real, valid_q marks prev
    // as real, so the first sample after reset only establishes history.
    // -------------------------------------------------------------------------
    logic sampled_q;
    logic valid_q;

    // -------------------------------------------------------------------------
    // Per-direction trackers
    // -------------------------------------------------------------------------
    logic [LIGHT_W-1:0] ns_cur;
    logic [LIGHT_W-1:0] ew_cur;
    logic               ns_seq_viol;
    logic               ew_seq_viol;
    logic               ns_dwell_viol;
    logic               ew_dwell_viol;

    tt_light_dwell #(
        .MIN_GREEN  (MIN_GREEN),
        .MIN_YELLOW (MIN_YELLOW),
        .DWELL_W    (DWELL_W)
    ) u_ns_dwell (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (ena),
        .tick_i       (tick),
        .valid_i      (valid_q),
        .light_i      (ns_light),
        .cur_o        (ns_cur),
        .seq_viol_o   (ns_seq_viol),
        .dwell_viol_o (ns_dwell_viol)
    );

    tt_light_dwell #(
        .MIN_GREEN  (MIN_GREEN),
        .MIN_YELLOW (MIN_YELLOW),
        .DWELL_W    (DWELL_W)
    ) u_ew_dwell (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (ena),
        .tick_i       (tick),
        .valid_i      (valid_q),
        .light_i      (ew_light),
        .cur_o        (ew_cur),
        .seq_viol_o   (ew_seq_viol),
        .dwell_viol_o (ew_dwell_viol)
    );

    // -------------------------------------------------------------------------
    // Violation detection on the registered sample, one code per cycle
    // -------------------------------------------------------------------------
    err_code_e viol_code;

    always_comb begin
        viol_code = ERR_NONE;
        if (!is_one_hot(ns_cur) || !is_one_hot(ew_cur)) begin
            viol_code = ERR_ENCODING;
        end else if ((ns_cur != LIGHT_RED) && (ew_cur != LIGHT_RED)) begin
            viol_code = ERR_CONFLICT;
        end else if (ns_seq_viol || ew_seq_viol) begin
            viol_code = ERR_SEQUENCE;
        end else if (ns_dwell_viol || ew_dwell_viol) begin
            viol_code = ERR_DWELL;
        end
    end

    // -------------------------------------------------------------------------
    // Status registers
    // -------------------------------------------------------------------------
    logic                  err_q;
    logic                  err_d;
    err_code_e             err_code_q;
    err_code_e             err_code_d;
    logic [VIOL_CNT_W-1:0] viol_cnt_q;
    logic [VIOL_CNT_W-1:0] viol_cnt_d;
    phase_e                phase_q;
    phase_e                phase_d;

    // Clear is applied first so a violation in the same cycle survives it
    // and restarts the count at 1.
    always_comb begin
        err_d      = err_q;
        err_code_d = err_code_q;
        viol_cnt_d = viol_cnt_q;
        phase_d    = decode_phase(ns_cur, ew_cur);
        if (clr) begin
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
            viol_cnt_d = '0;
        end
        if (viol_code != ERR_NONE) begin
            err_d      = 1'b1;
            err_code_d = viol_code;
            if (viol_cnt_d != VIOL_CNT_MAX) begin
                viol_cnt_d = viol_cnt_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sampled_q  <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            viol_cnt_q <= '0;
            phase_q    <= PHASE_ALL_RED;
        end else if (ena) begin
            sampled_q  <= 1'b1;
            valid_q    <= sampled_q;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            viol_cnt_q <= viol_cnt_d;
            phase_q    <= phase_d;
        end
    end

    assign err      = err_q;
    assign err_code = err_code_q;
    assign viol_cnt = viol_cnt_q;
    assign phase    = phase_q;

endmodule

// File: tb/tb_tt_light_monitor.sv
// -----------------------------------------------------------------------------
// tb_tt_light_monitor
// Self-checking bench for tt_light_monitor (default parameters). A table of
// light vectors with expected outputs feeds a scoreboard queue; each entry
// is compared two edges after it is driven. Hand-written sequences cover
// dwell limits, clear, saturation, enable freeze and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_tt_light_monitor;

    localparam logic [2:0] L_R   = 3'b100;
    localparam logic [2:0] L_Y   = 3'b010;
    localparam logic [2:0] L_G   = 3'b001;
    localparam logic [2:0] L_YG  = 3'b011;
    localparam logic [2:0] L_OFF = 3'b000;

`ifdef TT_LIGHT_MON_DWELL_EN
    localparam bit DWELL_ON = 1'b1;
`else
    localparam bit DWELL_ON = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       clr;
    logic       err;
    logic [2:0] err_code;
    logic [7:0] viol_cnt;
    logic [1:0] phase;

    tt_light_monitor dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .clr      (clr),
        .err      (err),
        .err_code (err_code),
        .viol_cnt (viol_cnt),
        .phase    (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       err;
        logic [2:0] code;
        logic [7:0] cnt;
        logic [1:0] ph;
    } vec_t;

    typedef struct {
        int         idx;
        logic       err;
        logic [2:0] code;
        logic [7:0] cnt;
        logic [1:0] ph;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic check_all(input string tag, input logic e, input logic [2:0] c,
                             input logic [7:0] n, input logic [1:0] p);
        check({tag, "_err"},      {31'd0, err},    {31'd0, e});
        check({tag, "_err_code"}, {29'd0, err_code}, {29'd0, c});
        check({tag, "_viol_cnt"}, {24'd0, viol_cnt}, {24'd0, n});
        check({tag, "_phase"},    {30'd0, phase},  {30'd0, p});
    endtask

    task automatic add_vec(input logic [2:0] ns, input logic [2:0] ew, input logic e,
                           input logic [2:0] c, input logic [7:0] n, input logic [1:0] p,
                           input int reps);
        vec_t v;
        v.ns = ns; v.ew = ew; v.err = e; v.code = c; v.cnt = n; v.ph = p;
        for (int i = 0; i < reps; i++) tbl.push_back(v);
    endtask

    task automatic compare_front();
        exp_t e;
        e = sb.pop_front();
        check_all($sformatf("vec%0d", e.idx), e.err, e.code, e.cnt, e.ph);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        ena      = 1'b1;
        clr      = 1'b0;
        ns_light = L_R;
        ew_light = L_R;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input logic [2:0] ns, input logic [2:0] ew);
        @(negedge clk);
        ns_light = ns;
        ew_light = ew;
    endtask

    task automatic wait2();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b1;
        clr      = 1'b0;
        ns_light = L_R;
        ew_light = L_R;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check_all("reset", 1'b0, 3'd0, 8'd0, 2'd0);

        // ---------------- table-driven scoreboard ----------------
        // Expected values are the outputs two edges after the vector is driven.
        add_vec(L_G,  L_R,   1'b0, 3'd0, 8'd0,  2'd1, 5);  // NS green 5
        add_vec(L_Y,  L_R,   1'b0, 3'd0, 8'd0,  2'd1, 3);  // NS yellow 3
        add_vec(L_R,  L_R,   1'b0, 3'd0, 8'd0,  2'd0, 1);  // all red
        add_vec(L_R,  L_G,   1'b0, 3'd0, 8'd0,  2'd2, 5);  // EW green 5
        add_vec(L_R,  L_Y,   1'b0, 3'd0, 8'd0,  2'd2, 3);  // EW yellow 3
        add_vec(L_R,  L_R,   1'b0, 3'd0, 8'd0,  2'd0, 1);  // all red
        add_vec(L_YG, L_R,   1'b1, 3'd1, 8'd1,  2'd3, 1);  // bad NS encoding
        add_vec(L_G,  L_G,   1'b1, 3'd2, 8'd2,  2'd3, 1);  // conflict
        add_vec(L_G,  L_G,   1'b1, 3'd2, 8'd3,  2'd3, 1);
        add_vec(L_G,  L_G,   1'b1, 3'd2, 8'd4,  2'd3, 1);
        add_vec(L_G,  L_R,   1'b1, 3'd3, 8'd5,  2'd1, 1);  // EW G->R
        add_vec(L_R,  L_R,   1'b1, 3'd3, 8'd6,  2'd0, 1);  // NS G->R
        add_vec(L_Y,  L_R,   1'b1, 3'd3, 8'd7,  2'd1, 1);  // NS R->Y
        add_vec(L_G,  L_R,   1'b1, 3'd3, 8'd8,  2'd1, 1);  // NS Y->G
        add_vec(L_G,  L_R,   1'b1, 3'd3, 8'd8,  2'd1, 1);  // steady, sticky
        add_vec(L_G,  L_Y,   1'b1, 3'd2, 8'd9,  2'd3, 1);  // conflict beats seq
        add_vec(L_R,  L_R,   1'b1, 3'd3, 8'd10, 2'd0, 1);  // NS G->R
        add_vec(L_R,  L_R,   1'b1, 3'd3, 8'd10, 2'd0, 1);  // steady
        add_vec(L_R,  L_OFF, 1'b1, 3'd1, 8'd11, 2'd3, 1);  // EW dark

        do_reset();
        for (int j = 0; j < tbl.size(); j++) begin
            exp_t e;
            @(negedge clk);
            if (sb.size() == 2) compare_front();
            ns_light = tbl[j].ns;
            ew_light = tbl[j].ew;
            e.idx  = j;
            e.err  = tbl[j].err;
            e.code = tbl[j].code;
            e.cnt  = tbl[j].cnt;
            e.ph   = tbl[j].ph;
            sb.push_back(e);
        end
        while (sb.size() > 0) begin
            @(negedge clk);
            compare_front();
        end

        // ---------------- dwell limits ----------------
        // Green held 2 then yellow
        do_reset();
        repeat (2) step(L_G, L_R);
        step(L_Y, L_R);
        wait2();
        check_all("green2", DWELL_ON, DWELL_ON ? 3'd4 : 3'd0, DWELL_ON ? 8'd1 : 8'd0, 2'd1);

        // Green held 4 (one short of legal) then yellow
        do_reset();
        repeat (4) step(L_G, L_R);
        step(L_Y, L_R);
        wait2();
        check_all("green4", DWELL_ON, DWELL_ON ? 3'd4 : 3'd0, DWELL_ON ? 8'd1 : 8'd0, 2'd1);

        // Green 5 is fine, yellow held 1 then red
        do_reset();
        repeat (5) step(L_G, L_R);
        step(L_Y, L_R);
        step(L_R, L_R);
        wait2();
        check_all("yellow1", DWELL_ON, DWELL_ON ? 3'd4 : 3'd0, DWELL_ON ? 8'd1 : 8'd0, 2'd0);

        // ---------------- clear without violation ----------------
        do_reset();
        step(L_G, L_G);
        step(L_G, L_R);
        wait2();
        check_all("pre_clr", 1'b1, 3'd3, 8'd2, 2'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_all("clr", 1'b0, 3'd0, 8'd0, 2'd1);

        // ---------------- conflict count and saturation ----------------
        do_reset();
        repeat (3) step(L_G, L_G);
        wait2();
        check_all("conflict3", 1'b1, 3'd2, 8'd3, 2'd3);
        repeat (297) step(L_G, L_G);
        wait2();
        check_all("saturate", 1'b1, 3'd2, 8'd255, 2'd3);

        // ---------------- enable low freezes everything ----------------
        @(negedge clk);
        ena      = 1'b0;
        ns_light = L_YG;
        ew_light = L_OFF;
        clr      = 1'b1;
        repeat (5) @(negedge clk);
        check_all("ena_mid", 1'b1, 3'd2, 8'd255, 2'd3);
        repeat (5) @(negedge clk);
        check_all("ena_end", 1'b1, 3'd2, 8'd255, 2'd3);

        // ---------------- clear with same-cycle violation ----------------
        // cur still holds the frozen conflict, so clr and code 2 coincide.
        ena      = 1'b1;
        clr      = 1'b1;
        ns_light = L_G;
        ew_light = L_G;
        @(negedge clk);
        clr = 1'b0;
        check_all("clr_viol", 1'b1, 3'd2, 8'd1, 2'd3);

        // ---------------- asynchronous reset mid-run ----------------
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all("async_rst", 1'b0, 3'd0, 8'd0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
